// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter slice: arbiter
// state encoding, default memory depth, word-index width helper and the
// NOP encoding that the fetch stage substitutes for an invalid fetch.
package imem_pkg;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int IMEM_DEPTH = 64;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   // Width of a word index into a memory of the given depth (at least 1 bit).
   function automatic int word_idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/imem_arbiter.sv
// Single-port instruction RAM arbiter between the fetch path (reads) and
// the program loader (writes). BOOT serves only the loader; RUN gives the
// loader priority, but fetch is forced through after STARVE_MAX loader
// wins in a row while fetch was waiting.
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int DEPTH      = IMEM_DEPTH,
   parameter int AW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         f_req,
   input  logic [AW-1:0]                f_addr,
   output logic                         f_gnt,
   output logic                         f_rvalid,
   output logic [31:0]                  f_rdata,
   output logic                         f_err,
   input  logic                         l_req,
   input  logic [AW-1:0]                l_addr,
   input  logic [31:0]                  l_wdata,
   output logic                         l_gnt,
   output logic                         l_err,
   input  logic                         boot_done,
   output logic                         in_boot,
   output logic                         mem_en,
   output logic                         mem_we,
   output logic [word_idx_w(DEPTH)-1:0] mem_addr,
   output logic [31:0]                  mem_wdata,
   input  logic [31:0]                  mem_rdata
);

   localparam int WIW = word_idx_w(DEPTH);
   localparam int CW  = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   state_t        state_r;
   logic [CW-1:0] starve_cnt_r;
   logic          f_rvalid_r;
   logic          f_err_r;
   logic          f_legal_s;
   logic          l_legal_s;
   logic          f_gnt_s;
   logic          l_gnt_s;

   // Word aligned and inside the DEPTH-word window (power-of-two depth).
   function automatic logic addr_legal(input logic [AW-1:0] addr);
      return (addr[1:0] == 2'b00) && ((addr >> (WIW + 2)) == {AW{1'b0}});
   endfunction

   assign f_legal_s = addr_legal(f_addr);
   assign l_legal_s = addr_legal(l_addr);

   // Grant selection: loader only in BOOT, starvation-bounded loader priority in RUN.
   always_comb begin
      f_gnt_s = 1'b0;
      l_gnt_s = 1'b0;
      if (reset) begin
         f_gnt_s = 1'b0;
         l_gnt_s = 1'b0;
      end else begin
         case (state_r)
            ST_BOOT: begin
               l_gnt_s = l_req;
               f_gnt_s = 1'b0;
            end
            ST_RUN: begin
               if (f_req && l_req) begin
                  f_gnt_s = (starve_cnt_r == STARVE_LIM);
                  l_gnt_s = (starve_cnt_r != STARVE_LIM);
               end else begin
                  f_gnt_s = f_req;
                  l_gnt_s = l_req;
               end
            end
            default: begin
               f_gnt_s = 1'b0;
               l_gnt_s = 1'b0;
            end
         endcase
      end
   end

   // RAM port drive; illegal grants are accepted but never reach the RAM.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {WIW{1'b0}};
      mem_wdata = 32'h0000_0000;
      l_err     = 1'b0;
      if (l_gnt_s) begin
         if (l_legal_s) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = l_addr[WIW+1:2];
            mem_wdata = l_wdata;
         end else begin
            l_err = 1'b1;
         end
      end else if (f_gnt_s) begin
         if (f_legal_s) begin
            mem_en   = 1'b1;
            mem_addr = f_addr[WIW+1:2];
         end else begin
            mem_en = 1'b0;
         end
      end else begin
         mem_en = 1'b0;
      end
   end

   // Phase FSM, starvation counter and the registered fetch-response flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_BOOT;
         starve_cnt_r <= {CW{1'b0}};
         f_rvalid_r   <= 1'b0;
         f_err_r      <= 1'b0;
      end else begin
         f_rvalid_r <= f_gnt_s;
         f_err_r    <= f_gnt_s && !f_legal_s;
         case (state_r)
            ST_BOOT: begin
               starve_cnt_r <= {CW{1'b0}};
               state_r      <= boot_done ? ST_RUN : ST_BOOT;
            end
            ST_RUN: begin
               state_r <= ST_RUN;
               if (f_gnt_s || !f_req) begin
                  starve_cnt_r <= {CW{1'b0}};
               end else if (l_gnt_s && (starve_cnt_r != STARVE_LIM)) begin
                  starve_cnt_r <= starve_cnt_r + CW'(1);
               end else begin
                  starve_cnt_r <= starve_cnt_r;
               end
            end
            default: begin
               state_r      <= ST_BOOT;
               starve_cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   // The RAM's own output register supplies the data in the response cycle;
   // the arbiter only forces it to zero when there is no good response.
   assign f_rvalid = f_rvalid_r;
   assign f_err    = f_err_r;
   assign f_rdata  = (f_rvalid_r && !f_err_r) ? mem_rdata : 32'h0000_0000;
   assign f_gnt    = f_gnt_s;
   assign l_gnt    = l_gnt_s;
   assign in_boot  = (state_r == ST_BOOT);

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: a behavioural reference model is
// checked against the DUT on every falling edge, directed scenarios pin the
// model with literal expectations, then randomized traffic runs.
module tb_imem_arbiter;

   localparam int DEPTH      = 64;
   localparam int STARVE_MAX = 4;

   logic        clk;
   logic        reset;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        f_err;
   logic        l_req;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;
   logic        l_gnt;
   logic        l_err;
   logic        boot_done;
   logic        in_boot;
   logic        mem_en;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   imem_arbiter #(.DEPTH(DEPTH), .AW(32), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_err(f_err),
      .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt), .l_err(l_err),
      .boot_done(boot_done), .in_boot(in_boot),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read RAM attached to the arbiter.
   bit [31:0] ram [0:DEPTH-1];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (a < DEPTH * 4);
   endfunction

   // Reference model state: phase, starvation run length, pending response, memory image.
   bit        m_boot = 1'b1;
   int        m_cnt  = 0;
   bit        m_rv   = 1'b0;
   bit        m_re   = 1'b0;
   bit [31:0] m_rd   = 32'h0;
   bit [31:0] shadow [0:DEPTH-1];

   // Compare DUT against the model every cycle, then advance the model.
   always @(negedge clk) begin : cmp
      bit efg, elg, fl, ll, een, ewe;
      if (reset)                begin efg = 1'b0; elg = 1'b0; end
      else if (m_boot)          begin efg = 1'b0; elg = l_req; end
      else if (f_req && l_req)  begin efg = (m_cnt == STARVE_MAX); elg = !efg; end
      else                      begin efg = f_req; elg = l_req; end
      fl  = legal(f_addr);
      ll  = legal(l_addr);
      een = (elg && ll) || (efg && fl);
      ewe = elg && ll;
      chk("f_gnt",   32'(f_gnt),   32'(efg));
      chk("l_gnt",   32'(l_gnt),   32'(elg));
      chk("l_err",   32'(l_err),   32'(elg && !ll));
      chk("in_boot", 32'(in_boot), 32'(reset || m_boot));
      chk("mem_en",  32'(mem_en),  32'(een));
      chk("mem_we",  32'(mem_we),  32'(ewe));
      chk("mem_addr", 32'(mem_addr), een ? (elg ? l_addr / 4 : f_addr / 4) : 32'h0);
      if (ewe || !een) chk("mem_wdata", mem_wdata, ewe ? l_wdata : 32'h0);
      chk("f_rvalid", 32'(f_rvalid), reset ? 32'h0 : 32'(m_rv));
      chk("f_err",    32'(f_err),    reset ? 32'h0 : 32'(m_re));
      chk("f_rdata",  f_rdata,       reset ? 32'h0 : m_rd);
      if (reset) begin
         m_boot = 1'b1; m_cnt = 0; m_rv = 1'b0; m_re = 1'b0; m_rd = 32'h0;
      end else begin
         m_rv = efg;
         m_re = efg && !fl;
         m_rd = (efg && fl) ? shadow[f_addr / 4] : 32'h0;
         if (ewe) shadow[l_addr / 4] = l_wdata;
         if (m_boot || efg || !f_req) m_cnt = 0;
         else if (elg)                m_cnt = m_cnt + 1;
         if (m_boot && boot_done) m_boot = 1'b0;
      end
   end

   logic        cap_fg, cap_lg, cap_rv, cap_fe, cap_le, cap_ib, cap_en, cap_we;
   logic [31:0] cap_rd;

   // One clock of stimulus; outputs captured just after the falling edge.
   task automatic step(input logic fr, input logic [31:0] fa, input logic lr,
                       input logic [31:0] la, input logic [31:0] ld, input logic bd);
      f_req = fr; f_addr = fa; l_req = lr; l_addr = la; l_wdata = ld; boot_done = bd;
      @(negedge clk); #1;
      cap_fg = f_gnt;  cap_lg = l_gnt;  cap_rv = f_rvalid; cap_rd = f_rdata;
      cap_fe = f_err;  cap_le = l_err;  cap_ib = in_boot;  cap_en = mem_en; cap_we = mem_we;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      return 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      else if (r == 1) return 32'(DEPTH * 4 + 4 * $urandom_range(0, 100));
      else if (r < 7)  return 32'(4 * $urandom_range(0, 7));
      else             return 32'(4 * $urandom_range(0, DEPTH - 1));
   endfunction

   localparam logic [31:0] DA = 32'hAAAA_0001;
   localparam logic [31:0] DB = 32'hBBBB_0002;
   localparam logic [31:0] DC = 32'hCCCC_0003;
   localparam logic [31:0] DD = 32'hDDDD_0004;

   initial begin : drive
      logic [9:0]  fpat, lpat;
      logic        fp, lp, bd;
      logic [31:0] fa, la, ld;
      reset = 1'b1; f_req = 1'b0; f_addr = 32'h0; l_req = 1'b0; l_addr = 32'h0;
      l_wdata = 32'h0; boot_done = 1'b0;
      @(posedge clk); #1;

      // Reset: grants suppressed, BOOT reported, no response.
      step(1'b1, 32'd0, 1'b1, 32'd0, DA, 1'b0);
      chk("rst_fgnt", 32'(cap_fg), 32'd0);
      chk("rst_lgnt", 32'(cap_lg), 32'd0);
      chk("rst_inboot", 32'(cap_ib), 32'd1);
      chk("rst_rvalid", 32'(cap_rv), 32'd0);
      reset = 1'b0;

      // Boot writes with fetch waiting.
      step(1'b1, 32'd4, 1'b1, 32'd0, DA, 1'b0);
      chk("boot_lgnt0", 32'(cap_lg), 32'd1);
      chk("boot_fgnt0", 32'(cap_fg), 32'd0);
      chk("boot_we0", 32'(cap_we), 32'd1);
      step(1'b1, 32'd4, 1'b1, 32'd4, DB, 1'b0);
      chk("boot_lgnt1", 32'(cap_lg), 32'd1);
      step(1'b1, 32'd4, 1'b1, 32'd8, DC, 1'b0);
      chk("boot_lgnt2", 32'(cap_lg), 32'd1);
      chk("boot_inboot", 32'(cap_ib), 32'd1);
      step(1'b1, 32'd4, 1'b0, 32'd0, 32'd0, 1'b1);
      chk("bootdone_inboot", 32'(cap_ib), 32'd1);
      chk("bootdone_fgnt", 32'(cap_fg), 32'd0);
      step(1'b1, 32'd4, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("run_inboot", 32'(cap_ib), 32'd0);
      chk("run_fgnt", 32'(cap_fg), 32'd1);
      step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("fetchB_rvalid", 32'(cap_rv), 32'd1);
      chk("fetchB_rdata", cap_rd, DB);
      chk("fetchB_err", 32'(cap_fe), 32'd0);

      // Both requesting continuously: L,L,L,L,F repeating.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 32'd0, 1'b1, 32'd12, $urandom, 1'b0);
         fpat[i] = cap_fg;
         lpat[i] = cap_lg;
      end
      chk("starve_fpat", 32'(fpat), 32'h0000_0210);
      chk("starve_lpat", 32'(lpat), 32'h0000_01EF);
      step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);

      // Illegal fetches and an illegal loader write.
      step(1'b1, 32'd6, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("mis_fgnt", 32'(cap_fg), 32'd1);
      chk("mis_memen", 32'(cap_en), 32'd0);
      step(1'b1, 32'd256, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("mis_rvalid", 32'(cap_rv), 32'd1);
      chk("mis_err", 32'(cap_fe), 32'd1);
      chk("mis_rdata", cap_rd, 32'd0);
      chk("oor_memen", 32'(cap_en), 32'd0);
      step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("oor_err", 32'(cap_fe), 32'd1);
      chk("oor_rdata", cap_rd, 32'd0);
      step(1'b0, 32'd0, 1'b1, 32'd256, DD, 1'b0);
      chk("lill_lgnt", 32'(cap_lg), 32'd1);
      chk("lill_lerr", 32'(cap_le), 32'd1);
      chk("lill_we", 32'(cap_we), 32'd0);

      // Read-after-write on the following cycle.
      step(1'b0, 32'd0, 1'b1, 32'd8, DD, 1'b0);
      chk("raw_we", 32'(cap_we), 32'd1);
      step(1'b1, 32'd8, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("raw_fgnt", 32'(cap_fg), 32'd1);
      step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("raw_rdata", cap_rd, DD);

      // Reset with a fetch response pending.
      step(1'b1, 32'd4, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("prerst_fgnt", 32'(cap_fg), 32'd1);
      reset = 1'b1;
      step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("midrst_rvalid", 32'(cap_rv), 32'd0);
      chk("midrst_inboot", 32'(cap_ib), 32'd1);
      reset = 1'b0;
      step(1'b1, 32'd4, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("postrst_fgnt", 32'(cap_fg), 32'd0);
      chk("postrst_rvalid", 32'(cap_rv), 32'd0);
      step(1'b1, 32'd4, 1'b0, 32'd0, 32'd0, 1'b1);
      chk("postrst_fgnt2", 32'(cap_fg), 32'd0);
      step(1'b1, 32'd4, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("reboot_fgnt", 32'(cap_fg), 32'd1);
      chk("reboot_inboot", 32'(cap_ib), 32'd0);
      step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("reboot_rdata", cap_rd, DB);

      // Randomized traffic; requests are held until granted.
      fp = 1'b0; lp = 1'b0; fa = 32'h0; la = 32'h0; ld = 32'h0;
      cap_fg = 1'b0; cap_lg = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (!fp || cap_fg) begin
            fp = ($urandom_range(0, 3) != 0);
            fa = rand_addr();
         end
         if (!lp || cap_lg) begin
            lp = ($urandom_range(0, 2) != 0);
            la = rand_addr();
            ld = $urandom;
         end
         bd    = ($urandom_range(0, 15) == 0);
         reset = ($urandom_range(0, 299) == 0);
         step(fp, fa, lp, la, ld, bd);
      end
      reset = 1'b0;
      step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Arbitrates the single-port instruction memory between two requesters.
- The core fetch path reads instructions.
- The program loader writes the program image at boot and for later patching.
- Sits between the fetch stage, the loader and a synchronous-read instruction RAM.
- Sequences a BOOT phase, in which only the loader is served, then a RUN phase with starvation-bounded loader priority.

Parameters:
DEPTH, 64, instruction memory depth in 32-bit words (power of 2)
AW, 32, byte address width of both requester ports
STARVE_MAX, 4, max consecutive loader grants while fetch waits before fetch is forced through

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
f_req  in  1  fetch read request; held until f_gnt
f_addr  in  AW  fetch byte address
f_gnt  out  1  fetch request accepted this cycle (combinational)
f_rvalid  out  1  fetch response valid, exactly 1 cycle after f_gnt
f_rdata  out  32  fetched instruction
f_err  out  1  fetch response is an error (misaligned or out of range)
l_req  in  1  loader write request; held until l_gnt
l_addr  in  AW  loader byte address
l_wdata  in  32  loader write data
l_gnt  out  1  loader request accepted this cycle (combinational)
l_err  out  1  accepted loader write was dropped (illegal address); same cycle as l_gnt
boot_done  in  1  loader signals image complete
in_boot  out  1  high while in BOOT state
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  log2(DEPTH)  RAM word index
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid 1 cycle after mem_en & !mem_we

Behaviour:
- Address legality: addr[1:0]==0 and addr < DEPTH*4. mem_addr = addr[log2(DEPTH)+1:2].
- State BOOT (reset state):
  - l_gnt = l_req; f_gnt = 0; in_boot = 1.
  - boot_done=1 moves to RUN next cycle. A loader write in the same cycle is still served.
- State RUN:
  - in_boot = 0; no return to BOOT except by reset.
  - Only one requester: it is granted.
  - Both requesting: loader wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt (0..STARVE_MAX):
  - +1 when the loader is granted while f_req=1.
  - Clears to 0 when fetch is granted or f_req=0.
  - Held in BOOT at 0.
- Granted legal loader write: mem_en=1, mem_we=1, mem_wdata=l_wdata, l_err=0.
- Granted illegal loader write: mem_en=0, l_err=1.
- Granted legal fetch: mem_en=1, mem_we=0. Next cycle f_rvalid=1, f_rdata=mem_rdata, f_err=0.
- Granted illegal fetch: mem_en=0. Next cycle f_rvalid=1, f_rdata=0, f_err=1.
- f_rvalid, f_rdata and f_err are registered. When no grant occurred the previous cycle: f_rvalid=0, f_rdata=0, f_err=0.
- At most one fetch is outstanding by construction (1-cycle latency). Back-to-back fetch grants give f_rvalid high on consecutive cycles.
- Read-after-write: a fetch granted the cycle after a write to the same word returns the new data (RAM is write-first or sequential).
- Reset (any time, including with a response pending):
  - State goes to BOOT, starve_cnt=0, f_rvalid=0, f_rdata=0, f_err=0.
  - Any pending response is discarded.
  - Combinational grants and mem_en are 0 while reset is high.
- No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

Decomposition:
- Shared package imem_pkg holds:
  - the state enum (ST_BOOT, ST_RUN),
  - IMEM_DEPTH,
  - the word-index width function,
  - the NOP encoding 32'h00000013 used by the fetch stage.
- No sub-module is required. The grant logic is small enough to stay inline.

Test Plan:
- Reset, then l_req to addrs 0,4,8 with data A,B,C while f_req=1 -> l_gnt each cycle, f_gnt=0, in_boot=1; boot_done -> in_boot=0 next cycle.
- RUN, fetch addr 4 -> f_gnt same cycle, next cycle f_rvalid=1, f_rdata=B, f_err=0.
- RUN, f_req and l_req held high continuously, STARVE_MAX=4 -> grant pattern L,L,L,L,F repeating; fetch is never waiting more than 4 cycles.
- Fetch addr 6 (misaligned) and addr 256 (out of range, DEPTH=64) -> f_rvalid=1, f_err=1, f_rdata=0, mem_en=0. Loader write to 256 -> l_gnt=1, l_err=1, no mem_we.
- Write D to addr 8, fetch addr 8 on the next cycle -> f_rdata=D.
- Assert reset the cycle after a fetch grant -> f_rvalid stays 0, in_boot=1, f_gnt=0 until a new boot_done.
